lc3_mem_arbiter: RTL
====================

# lc3_mem_arbiter

Two-port memory arbiter and access sequencer for the LC-3 CPU's single-port synchronous RAM. It shares the RAM between the CPU memory interface (MAR/MDR/MEM_EN/MEM_W, ready "R") and a debug/loader port driven from the board switches and keys. It latches each request, sequences the RAM enable, write and read-latency cycles, and returns a one-cycle ready pulse to the requester. Round-robin fairness applies when both ports request in the same cycle.

## Interface
- RAM_LAT, default 1: RAM read latency in cycles, from the `ram_en` cycle to the cycle `ram_rdata` is valid. Legal range is 1..15.
- clk  in  1  system clock; all logic acts on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- cpu_en  in  1  CPU request (MEM_EN); held until `cpu_ready` is sampled high.
- cpu_we  in  1  CPU write (MEM_W); 0 means read.
- cpu_addr  in  16  CPU address (MAR).
- cpu_wdata  in  16  CPU write data (MDR).
- cpu_rdata  out  16  CPU read data; holds the last completed CPU read.
- cpu_ready  out  1  CPU completion pulse (R).
- dbg_en, dbg_we, dbg_addr[15:0], dbg_wdata[15:0]  in  debug request; same semantics as the CPU inputs.
- dbg_rdata  out  16  debug read data.
- dbg_ready  out  1  debug completion pulse.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  16  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data; valid RAM_LAT cycles after the `ram_en` cycle.
- busy  out  1  high when the FSM is not in IDLE.
- grant  out  1  current or last owner; 0 is CPU, 1 is debug.

## Operation
- **States:** IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - Sample `cpu_en` and `dbg_en`.
  - If either is high, choose the owner, latch its we/addr/wdata into internal registers, set `grant`, and go to ACCESS.
- **Arbitration:**
  - Single requester: that requester wins.
  - Both requesting: the winner is the port that is not `last_owner`.
  - `last_owner` updates to the winner at each grant.
  - The loser keeps its en asserted and is granted on the next IDLE.
- **ACCESS** lasts 1 cycle:
  - `ram_en`=1, `ram_we` = latched we, and `ram_addr`/`ram_wdata` from the latched registers.
  - A write goes to DONE.
  - A read loads the counter with RAM_LAT and goes to WAIT.
- **WAIT:**
  - The counter decrements each cycle. `ram_en`=0 and `ram_we`=0.
  - When the counter reaches 1, capture `ram_rdata` into the owner's rdata register and go to DONE.
- **DONE** lasts 1 cycle:
  - The owner's ready is 1, and its rdata is valid for a read.
  - Go to IDLE.
- **Outputs outside ACCESS:** `ram_addr`/`ram_wdata` hold their latched values; only `ram_en`/`ram_we` are qualified by state.
- **Request changes after grant:** changes to en/addr/we/wdata after the IDLE sample are ignored. The transaction completes and ready still pulses even if en dropped.
- **Requester protocol:** the requester must drop en the cycle after it sees ready, as in LC-3 state 33/35 behaviour. An en still high in IDLE after DONE is treated as a new request.
- **rdata after writes:** a write never modifies either rdata register.

## Timing
- **Reset values:** state=IDLE; `cpu_ready`, `dbg_ready`, `ram_en`, `ram_we`, `busy` = 0; `grant`=0; `last_owner`=debug, so the CPU wins the first tie; `cpu_rdata`, `dbg_rdata`, `ram_addr`, `ram_wdata` = 0; counter=0.
- **Write latency:** en sampled in IDLE at cycle 0, ACCESS at cycle 1, ready at cycle 2.
- **Read latency:** ready at cycle 2+RAM_LAT. With RAM_LAT=1, ready is at cycle 3.
- **Throughput:** the minimum gap between grants is 3 cycles for a write and 3+RAM_LAT cycles for a read, because IDLE is always one cycle.
- **Ready pulses:** exactly one ready pulse per grant, never on both ports in the same cycle, and never outside DONE.
- **`busy`:** high in ACCESS, WAIT and DONE.
- **Reset mid-transaction:** the FSM returns to IDLE on the next edge and no ready is issued.
  - If reset is asserted during ACCESS of a write, the RAM samples the write on that same edge and the write lands.
  - If reset is asserted in WAIT, the read is discarded and rdata is reset to 0.
- **RAM_LAT bounds:** RAM_LAT outside 1..15 is a configuration error; behaviour is unspecified.

## Test plan
- **Reset.** Hold `reset_n`=0 for 2 cycles with both en high → all outputs are 0, `busy`=0, and no `ram_en` during reset.
- **CPU write then read.** CPU write addr 0x3000, data 0x1234 → `ram_en`=`ram_we`=1 at cycle 1 and `cpu_ready` at cycle 2. Then a CPU read of 0x3000 → `cpu_ready` at cycle 3 with `cpu_rdata`=0x1234 (RAM_LAT=1).
- **Tie after reset.** Both ports read in the same cycle after reset → CPU is served first (`grant`=0) and debug is served second. `dbg_ready` comes 4 cycles after `cpu_ready` (3 cycles with a debug write), and `dbg_rdata` is correct.
- **Continuous contention.** Both en held continuously for 6 transactions → grants alternate CPU, debug, CPU, …, and no port is granted twice in a row.
- **RAM_LAT=3.** Debug read of 0x0000 holding 0xBEEF → ready at cycle 5 with 0xBEEF, and `cpu_rdata` is unchanged.
- **Mid-operation reset.** Assert reset in WAIT of a CPU read → no `cpu_ready` and `cpu_rdata`=0. The next request after reset completes normally.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous single-port RAM between the LC-3 CPU memory interface
// and a debug/loader port, with round-robin arbitration on simultaneous requests.
module lc3_mem_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_en,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic        grant
);

  localparam logic [3:0] LAT_INIT = 4'(RAM_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic        last_owner;
  logic        lat_we;
  logic [3:0]  cnt;
  logic        winner;
  logic        take;

  // On a tie the port that did not own the previous grant wins.
  assign winner = (cpu_en && dbg_en) ? ~last_owner : dbg_en;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    cpu_ready  = 1'b0;
    dbg_ready  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cpu_en || dbg_en) begin
          take       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_en     = 1'b1;
        ram_we     = lat_we;
        state_next = lat_we ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt <= 4'd1) state_next = DONE;
      end
      DONE: begin
        cpu_ready  = ~grant;
        dbg_ready  = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      cnt        <= 4'd0;
      ram_addr   <= 16'h0000;
      ram_wdata  <= 16'h0000;
      cpu_rdata  <= 16'h0000;
      dbg_rdata  <= 16'h0000;
    end else begin
      state <= state_next;
      if (take) begin
        grant      <= winner;
        last_owner <= winner;
        lat_we     <= winner ? dbg_we    : cpu_we;
        ram_addr   <= winner ? dbg_addr  : cpu_addr;
        ram_wdata  <= winner ? dbg_wdata : cpu_wdata;
      end
      // The counter tracks the cycles until ram_rdata is valid for this read.
      if (state == ACCESS && !lat_we) begin
        cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == WAIT && cnt <= 4'd1) begin
        if (grant) dbg_rdata <= ram_rdata;
        else       cpu_rdata <= ram_rdata;
      end
    end
  end

endmodule
